// File: rtl/jtframe_rst_pkg.sv
// Shared types and helpers for the PLL-lock watchdog and reset sequencer.
package jtframe_rst_pkg;

  typedef enum logic [2:0] {
    PLLRST,
    WAITLOCK,
    RELEASE,
    RUN,
    FAIL
  } rst_state_t;

  // Width of a counter that must be able to hold the value val without wrapping.
  function automatic int cnt_w(input int val);
    return (val < 1) ? 1 : $clog2(val + 1);
  endfunction

endpackage

// File: rtl/jtframe_sync2.sv
// Two-flop synchroniser for asynchronous single-bit inputs into clk_sys.
module jtframe_sync2 (
  input  logic clk_sys,
  input  logic RESET,
  input  logic din,
  output logic dout
);

  logic sync_p0;

  always_ff @(posedge clk_sys or posedge RESET) begin
    if (RESET) begin
      sync_p0 <= 1'b0;
      dout    <= 1'b0;
    end else begin
      sync_p0 <= din;
      dout    <= sync_p0;
    end
  end

endmodule

// File: rtl/jtframe_rst_seq.sv
// PLL-lock watchdog with bounded retries, stable-lock qualification and an
// ordered release of CHANNELS reset outputs, plus soft-reset handling.
module jtframe_rst_seq
  import jtframe_rst_pkg::*;
#(
  parameter int CHANNELS = 3,
  parameter int HOLD     = 255,
  parameter int STABLE   = 1024,
  parameter int LOCKWAIT = 65535,
  parameter int GAP      = 64,
  parameter int MAXRETRY = 7
) (
  input  logic                clk_sys,
  input  logic                RESET,
  input  logic                pll_locked,
  input  logic                rst_req,
  output logic                pll_rst,
  output logic [CHANNELS-1:0] rst_out,
  output logic                ready,
  output logic                fail,
  output logic [3:0]          retry_cnt,
  output logic [7:0]          lost_cnt
);

  localparam int HOLD_W = cnt_w(HOLD);
  localparam int STB_W  = cnt_w(STABLE);
  localparam int TO_W   = cnt_w(LOCKWAIT);
  localparam int GAP_W  = cnt_w(GAP);

  rst_state_t          st;
  logic                lk, lk_d, rq, rq_d;
  logic                loss, rq_rise, qual, tmo;
  logic [HOLD_W-1:0]   hold_cnt;
  logic [STB_W-1:0]    stab_cnt;
  logic [TO_W-1:0]     to_cnt;
  logic [GAP_W-1:0]    gap_cnt;
  logic [3:0]          retry_nxt;
  logic [CHANNELS-1:0] rst_nxt;

  jtframe_sync2 u_sync_lock (
    .clk_sys (clk_sys),
    .RESET   (RESET),
    .din     (pll_locked),
    .dout    (lk)
  );

  jtframe_sync2 u_sync_req (
    .clk_sys (clk_sys),
    .RESET   (RESET),
    .din     (rst_req),
    .dout    (rq)
  );

  assign loss      = lk_d & ~lk;
  assign rq_rise   = rq & ~rq_d;
  // The qualifying cycle is the STABLE-th consecutive locked cycle.
  assign qual      = lk && (stab_cnt == STB_W'(STABLE - 1));
  assign tmo       = (to_cnt == TO_W'(LOCKWAIT - 1));
  assign retry_nxt = retry_cnt + 4'd1;
  // Channels release low-to-high, so a left shift drops the next one.
  assign rst_nxt   = rst_out << 1;

  always_ff @(posedge clk_sys or posedge RESET) begin
    if (RESET) begin
      st        <= WAITLOCK;
      pll_rst   <= 1'b0;
      rst_out   <= '1;
      ready     <= 1'b0;
      fail      <= 1'b0;
      retry_cnt <= 4'd0;
      lost_cnt  <= 8'd0;
      hold_cnt  <= '0;
      stab_cnt  <= '0;
      to_cnt    <= '0;
      gap_cnt   <= '0;
      lk_d      <= 1'b0;
      rq_d      <= 1'b0;
    end else begin
      lk_d <= lk;
      rq_d <= rq;
      // Timers idle at zero outside their own state, so every entry starts clean.
      if (st != PLLRST) hold_cnt <= '0;
      if (st != WAITLOCK) begin
        stab_cnt <= '0;
        to_cnt   <= '0;
      end
      if (st != RELEASE) gap_cnt <= '0;

      if (loss && (st inside {WAITLOCK, RELEASE, RUN})) begin
        st      <= PLLRST;
        pll_rst <= 1'b1;
        rst_out <= '1;
        ready   <= 1'b0;
        if (lost_cnt != 8'hff) lost_cnt <= lost_cnt + 8'd1;
      end else begin
        case (st)
          PLLRST: begin
            if (hold_cnt == HOLD_W'(HOLD)) begin
              st      <= WAITLOCK;
              pll_rst <= 1'b0;
            end else begin
              hold_cnt <= hold_cnt + HOLD_W'(1);
            end
          end
          WAITLOCK: begin
            stab_cnt <= lk ? stab_cnt + STB_W'(1) : '0;
            to_cnt   <= to_cnt + TO_W'(1);
            if (qual) begin
              st        <= RELEASE;
              retry_cnt <= 4'd0;
            end else if (tmo) begin
              retry_cnt <= retry_nxt;
              if (retry_nxt == 4'(MAXRETRY)) begin
                st   <= FAIL;
                fail <= 1'b1;
              end else begin
                st      <= PLLRST;
                pll_rst <= 1'b1;
              end
            end
          end
          RELEASE, RUN: begin
            if (rq) begin
              st      <= RELEASE;
              rst_out <= '1;
              ready   <= 1'b0;
              gap_cnt <= '0;
            end else if (st == RELEASE) begin
              if (gap_cnt == GAP_W'(GAP - 1)) begin
                gap_cnt <= '0;
                rst_out <= rst_nxt;
                if (rst_nxt == '0) begin
                  st    <= RUN;
                  ready <= 1'b1;
                end
              end else begin
                gap_cnt <= gap_cnt + GAP_W'(1);
              end
            end
          end
          FAIL: begin
            rst_out <= '1;
            pll_rst <= 1'b0;
            if (rq_rise) begin
              st        <= PLLRST;
              pll_rst   <= 1'b1;
              fail      <= 1'b0;
              retry_cnt <= 4'd0;
            end
          end
          default: st <= WAITLOCK;
        endcase
      end
    end
  end

endmodule
